// File: rtl/fsm_step_sequencer_if.sv
// Host/board-side bundle for the step sequencer: controls, script writes and the FSM hookup.
interface fsm_step_sequencer_if #(
  parameter int DIV_W = 24
);
  logic             btn_step;
  logic             mode_auto;
  logic             run;
  logic [DIV_W-1:0] div_load;
  logic [1:0]       sw_raw;
  logic             use_seq;
  logic             seq_wr_en;
  logic [1:0]       seq_wr_data;
  logic             seq_clr;
  logic             fsm_out;
  logic             ctrl_out;
  logic [1:0]       sw_out;
  logic [7:0]       step_count;
  logic [7:0]       hist;
  logic             seq_done;
  logic             busy;

  modport master (
    output btn_step, mode_auto, run, div_load, sw_raw, use_seq,
           seq_wr_en, seq_wr_data, seq_clr, fsm_out,
    input  ctrl_out, sw_out, step_count, hist, seq_done, busy
  );

  modport slave (
    input  btn_step, mode_auto, run, div_load, sw_raw, use_seq,
           seq_wr_en, seq_wr_data, seq_clr, fsm_out,
    output ctrl_out, sw_out, step_count, hist, seq_done, busy
  );
endinterface

// File: rtl/fsm_step_sequencer.sv
// Step-enable generator for the 2-bit-switch Moore FSM: debounced manual steps or divided auto steps.
// ctrl_out pulses one cycle after a request (one in flight, extras dropped); fsm_out captured the cycle after.
module fsm_step_sequencer #(
  parameter int DIV_W     = 24,
  parameter int DB_CYC    = 16,
  parameter int SEQ_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  fsm_step_sequencer_if.slave bus
);
  localparam int AW  = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
  localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_AUTO, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db_level;
  logic [DBW-1:0]   r_db_cnt;
  logic             w_db_hit;
  logic             w_btn_rise;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_last;
  logic             w_div_term;

  logic [1:0]       r_buf [SEQ_DEPTH];
  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_ptr;
  logic             w_buf_full;
  logic             w_seq_exh;

  logic             w_req;
  logic             r_ctrl;
  logic             r_cap;
  logic [1:0]       r_sw_raw;
  logic [7:0]       r_step_count;
  logic [7:0]       r_hist;
  logic             r_seq_done;

  // Button: 2-FF synchronizer, then a level that flips only after DB_CYC differing samples.
  assign w_db_hit   = (r_sync2 != r_db_level) && (r_db_cnt == DBW'(DB_CYC - 1));
  assign w_btn_rise = w_db_hit && r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1 <= bus.btn_step;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (w_db_hit) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end

  // A period of 0 behaves as 1; >= lets a shrunken div_load terminate at the next compare.
  assign w_div_last = (bus.div_load == '0) ? '0 : bus.div_load - DIV_W'(1);
  assign w_div_term = (r_state == S_AUTO) && (r_div >= w_div_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_div_term || (r_state != S_AUTO)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_buf_full = (r_wr_cnt == (AW + 1)'(SEQ_DEPTH));
  assign w_seq_exh  = bus.use_seq && (r_rd_ptr == r_wr_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < SEQ_DEPTH; i++) begin
        r_buf[i] <= 2'b00;
      end
    end else if (bus.seq_clr) begin
      r_wr_cnt <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (bus.seq_wr_en && !w_buf_full) begin
        r_buf[r_wr_cnt[AW-1:0]] <= bus.seq_wr_data;
        r_wr_cnt                <= r_wr_cnt + (AW + 1)'(1);
      end
      if (r_ctrl && bus.use_seq && (r_rd_ptr != r_wr_cnt)) begin
        r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // An exhausted script suppresses requests so no step slips out while DONE is being entered.
  assign w_req = bus.run && !w_seq_exh &&
                 (w_div_term || ((r_state == S_MANUAL) && w_btn_rise));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= 1'b0;
      r_cap    <= 1'b0;
      r_sw_raw <= 2'b00;
    end else begin
      r_ctrl   <= w_req && !r_ctrl;
      r_cap    <= r_ctrl;
      r_sw_raw <= bus.sw_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.seq_clr) begin
      r_step_count <= 8'd0;
      r_hist       <= 8'd0;
    end else if (r_cap) begin
      r_hist <= {r_hist[6:0], bus.fsm_out};
      if (r_step_count != 8'hFF) begin
        r_step_count <= r_step_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          if (w_seq_exh)          w_state_nxt = S_DONE;
          else if (bus.mode_auto) w_state_nxt = S_AUTO;
          else                    w_state_nxt = S_MANUAL;
        end
      end
      S_MANUAL, S_AUTO: begin
        if (!bus.run)           w_state_nxt = S_IDLE;
        else if (w_seq_exh)     w_state_nxt = S_DONE;
        else if (bus.mode_auto) w_state_nxt = S_AUTO;
        else                    w_state_nxt = S_MANUAL;
      end
      S_DONE: begin
        if (!bus.run || bus.seq_clr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bus.seq_clr) begin
      r_seq_done <= 1'b0;
    end else if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
      r_seq_done <= 1'b1;
    end
  end

  assign bus.ctrl_out   = r_ctrl;
  assign bus.sw_out     = bus.use_seq ? r_buf[r_rd_ptr[AW-1:0]] : r_sw_raw;
  assign bus.step_count = r_step_count;
  assign bus.hist       = r_hist;
  assign bus.seq_done   = r_seq_done;
  assign bus.busy       = (r_state == S_MANUAL) || (r_state == S_AUTO);
endmodule
